// File: rtl/trivium_ctrl.sv
// trivium_ctrl: sequences key/IV collection, core load and warm-up, then
// XORs each received byte with 8 fresh keystream bits for the UART transmitter.
module trivium_ctrl #(
    parameter int KEY_BYTES     = 10,
    parameter int IV_BYTES      = 10,
    parameter int WARMUP_CYCLES = 1152
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   rekey,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic                   core_load,
    output logic [8*KEY_BYTES-1:0] core_key,
    output logic [8*IV_BYTES-1:0]  core_iv,
    output logic                   core_step,
    input  logic                   core_ks,
    output logic                   ready,
    output logic                   overrun
);
    localparam int MAXB = KEY_BYTES > IV_BYTES ? KEY_BYTES : IV_BYTES;
    localparam int BW   = $clog2(MAXB + 1);
    localparam int WW   = $clog2(WARMUP_CYCLES + 1);

    typedef enum logic [2:0] {S_KEY, S_IV, S_LOAD, S_WARM, S_READY, S_GEN, S_SEND} state_t;

    state_t        state, state_next;
    logic [BW-1:0] byte_cnt;
    logic [WW-1:0] warm_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    hold;
    logic [6:0]    ks;
    logic          go, busy, key_last, iv_last, warm_last;

    assign go        = ena & ~rekey;
    assign key_last  = byte_cnt == BW'(KEY_BYTES - 1);
    assign iv_last   = byte_cnt == BW'(IV_BYTES - 1);
    assign warm_last = warm_cnt == WW'(WARMUP_CYCLES - 1);
    assign ready     = state == S_READY;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_KEY;
        else        state <= state_next;

    // busy marks the states in which an arriving byte is an overrun
    always_comb begin
        state_next = state;
        core_load  = 1'b0;
        core_step  = 1'b0;
        busy       = 1'b0;
        case (state)
            S_KEY:   if (rx_valid && key_last) state_next = S_IV;
            S_IV:    if (rx_valid && iv_last) state_next = S_LOAD;
            S_LOAD:  begin
                core_load  = go;
                busy       = 1'b1;
                state_next = S_WARM;
            end
            S_WARM:  begin
                core_step  = go;
                busy       = 1'b1;
                state_next = warm_last ? S_READY : S_WARM;
            end
            S_READY: if (rx_valid) state_next = S_GEN;
            S_GEN:   begin
                core_step  = go;
                busy       = 1'b1;
                state_next = &bit_cnt ? S_SEND : S_GEN;
            end
            S_SEND:  begin
                busy       = 1'b1;
                state_next = tx_ready ? S_READY : S_SEND;
            end
            default: state_next = S_KEY;
        endcase
        if (rekey) state_next = S_KEY;
        if (!ena) state_next = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            warm_cnt <= '0;
            bit_cnt  <= '0;
            hold     <= '0;
            ks       <= '0;
            core_key <= '0;
            core_iv  <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            overrun  <= 1'b0;
        end else if (ena && rekey) begin
            byte_cnt <= '0;
            warm_cnt <= '0;
            bit_cnt  <= '0;
            overrun  <= 1'b0;
            tx_valid <= 1'b0;
        end else if (go) begin
            if (rx_valid && busy) overrun <= 1'b1;
            case (state)
                S_KEY: if (rx_valid) begin
                    for (int i = 0; i < KEY_BYTES; i++)
                        if (byte_cnt == BW'(i)) core_key[8*i +: 8] <= rx_data;
                    byte_cnt <= key_last ? '0 : byte_cnt + 1'b1;
                end
                S_IV: if (rx_valid) begin
                    for (int i = 0; i < IV_BYTES; i++)
                        if (byte_cnt == BW'(i)) core_iv[8*i +: 8] <= rx_data;
                    byte_cnt <= iv_last ? '0 : byte_cnt + 1'b1;
                end
                S_WARM: warm_cnt <= warm_last ? '0 : warm_cnt + 1'b1;
                S_READY: if (rx_valid) hold <= rx_data;
                S_GEN: begin
                    // keystream shifts in from the top so step 0 ends up in bit 0
                    ks      <= {core_ks, ks[6:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (&bit_cnt) begin
                        tx_data  <= hold ^ {core_ks, ks};
                        tx_valid <= 1'b1;
                    end
                end
                S_SEND: if (tx_ready) tx_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_trivium_ctrl.sv
// tb_trivium_ctrl: random key/IV/plaintext sessions against a bit-stream core
// model; ciphertext expected from stream position 1152 + 8*byte_index.
module tb_trivium_ctrl;
    localparam int WARM = 1152;

    logic        clk = 0, rst_n = 0, ena = 1, rekey = 0, rx_valid = 0, tx_ready = 0;
    logic [7:0]  rx_data = 0, tx_data;
    logic        tx_valid, core_load, core_step, core_ks, ready, overrun;
    logic [79:0] core_key, core_iv, exp_key = 0, exp_iv = 0;

    bit stream [0:2047];
    int idx = 0, steps = 0, loads = 0, run = 0, lts = 0, n_bytes = 0;
    int checks = 0, errors = 0;
    bit ld_s, st_s, prev_load;

    trivium_ctrl dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rekey(rekey),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .core_load(core_load), .core_key(core_key), .core_iv(core_iv),
        .core_step(core_step), .core_ks(core_ks),
        .ready(ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    assign core_ks = stream[idx];

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // core model: a load rewinds the stream, each step advances it
    always @(posedge clk) begin
        #1;
        if (ld_s) idx = 0;
        else if (st_s && idx < 2047) idx = idx + 1;
    end

    always @(negedge clk) begin
        ld_s = core_load;
        st_s = core_step;
        if (prev_load) lts = int'(core_step);
        prev_load = core_load;
        if (core_load) loads++;
        if (core_step) begin steps++; run++; end else run = 0;
        if (core_load | core_step) chk("load_step_excl", core_load & core_step, 0);
    end

    function automatic logic [7:0] ks_byte(input int n);
        for (int i = 0; i < 8; i++) ks_byte[i] = stream[WARM + 8*n + i];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1;
        rx_data  = b;
        tick();
        rx_valid = 0;
    endtask

    task automatic session(input bit fixed, input bit warm_rx, input int abort_at);
        logic [7:0] b;
        int n, s0, l0;
        for (int i = 0; i < 20; i++) begin
            b = fixed ? 8'(i) : 8'($urandom);
            if (!fixed) begin
                repeat ($urandom_range(0, 2)) begin
                    ena = 0; rx_valid = 1'($urandom_range(0, 1)); rx_data = 8'($urandom); tick();
                end
                ena = 1; rx_valid = 0;
                repeat ($urandom_range(0, 1)) tick();
            end
            if (i < 10) exp_key[8*i +: 8] = b;
            else exp_iv[8*(i-10) +: 8] = b;
            send_byte(b);
        end
        chk("core_key", core_key, fixed ? 80'h09080706050403020100 : exp_key);
        chk("core_iv", core_iv, fixed ? 80'h131211100F0E0D0C0B0A : exp_iv);
        s0 = steps; l0 = loads; n_bytes = 0; n = 0;
        while (!ready && n < 3000) begin
            if (abort_at > 0 && steps - s0 == abort_at) begin
                rx_valid = 0;
                rst_n = 0;
                #1;
                chk("rst_tx_valid", tx_valid, 0);
                chk("rst_tx_data", tx_data, 0);
                chk("rst_core_load", core_load, 0);
                chk("rst_core_step", core_step, 0);
                chk("rst_ready", ready, 0);
                chk("rst_overrun", overrun, 0);
                chk("rst_core_key", core_key, 0);
                chk("rst_core_iv", core_iv, 0);
                tick(); tick();
                rst_n = 1;
                tick();
                return;
            end
            rx_valid = warm_rx && n == 300;
            rx_data = 8'($urandom);
            tick();
            n++;
        end
        rx_valid = 0;
        chk("warm_ready", ready, 1);
        chk("warm_steps", steps - s0, WARM);
        chk("warm_run", run, WARM);
        chk("load_pulses", loads - l0, 1);
        chk("load_to_step", lts, 1);
        chk("overrun_warm", overrun, warm_rx);
    endtask

    task automatic crypt(input logic [7:0] b, input int delay, input int gap_at, input int gap_len,
                         input bit gen_rx, input bit do_rekey);
        logic [7:0] exp;
        int lat, s0;
        bit ok, seen;
        exp = b ^ ks_byte(n_bytes);
        s0 = steps;
        tx_ready = delay == 0;
        send_byte(b);
        lat = 1;
        while (!tx_valid && lat < 60) begin
            rx_valid = gen_rx && lat == 2;
            rx_data = ~b;
            ena = !(gap_len > 0 && lat > gap_at && lat <= gap_at + gap_len);
            tick();
            lat++;
        end
        rx_valid = 0; ena = 1;
        chk("latency", lat, 9 + gap_len);
        chk("tx_data", tx_data, exp);
        chk("gen_steps", steps - s0, 8);
        n_bytes++;
        if (do_rekey) begin
            rekey = 1; rx_valid = 1; rx_data = 8'($urandom);
            tick();
            rekey = 0; rx_valid = 0;
            chk("rekey_tx_valid", tx_valid, 0);
            chk("rekey_overrun", overrun, 0);
            chk("rekey_ready", ready, 0);
            chk("rekey_key_kept", core_key, exp_key);
            chk("rekey_iv_kept", core_iv, exp_iv);
            return;
        end
        if (delay == 0) begin
            tick();
        end else begin
            ok = 1;
            repeat (delay) begin
                tick();
                if (!tx_valid || tx_data !== exp) ok = 0;
            end
            chk("tx_hold", ok, 1);
            tx_ready = 1;
            tick();
        end
        tx_ready = 0;
        chk("tx_done", tx_valid, 0);
        chk("back_ready", ready, 1);
        if (gen_rx) begin
            seen = 0;
            repeat (12) begin
                tick();
                if (tx_valid) seen = 1;
            end
            chk("dropped_byte", seen, 0);
            chk("overrun_gen", overrun, 1);
        end
        chk("no_extra_step", steps - s0, 8);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) stream[i] = 1'($urandom_range(0, 1));
        stream[WARM+0] = 1; stream[WARM+1] = 0; stream[WARM+2] = 1; stream[WARM+3] = 0;
        stream[WARM+4] = 0; stream[WARM+5] = 1; stream[WARM+6] = 1; stream[WARM+7] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx_valid", tx_valid, 0);
        chk("reset_tx_data", tx_data, 0);
        chk("reset_core_load", core_load, 0);
        chk("reset_core_step", core_step, 0);
        chk("reset_ready", ready, 0);
        chk("reset_overrun", overrun, 0);
        chk("reset_core_key", core_key, 0);
        chk("reset_core_iv", core_iv, 0);
        rst_n = 1;
        tick();

        session(1, 0, 0);
        crypt(8'hA5, 0, 0, 0, 0, 0);
        chk("directed_cipher", tx_data, 8'hC0);
        crypt(8'($urandom), 20, 0, 0, 0, 0);
        repeat (4) crypt(8'($urandom), $urandom_range(0, 4), 0, 0, 0, 0);
        crypt(8'($urandom), 2, 4, 5, 0, 0);
        crypt(8'($urandom), 1, 0, 0, 1, 0);
        crypt(8'($urandom), 3, 0, 0, 0, 1);

        session(0, 1, 0);
        repeat (3) crypt(8'($urandom), $urandom_range(0, 3), $urandom_range(1, 6), $urandom_range(0, 3), 0, 0);

        rekey = 1;
        tick();
        rekey = 0;
        session(0, 0, 500);
        session(0, 0, 0);
        repeat (3) crypt(8'($urandom), $urandom_range(0, 3), 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
